// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared state encoding and iic_com command codes for the EEPROM BIST sequencer
package eeprom_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, CMP, DONE} state_t;
  localparam logic [1:0] IIC_IDLE = 2'b00;
  localparam logic [1:0] IIC_WR   = 2'b01;
  localparam logic [1:0] IIC_RD   = 2'b10;
endpackage

// File: rtl/eeprom_pat_gen.sv
// eeprom_pat_gen: maps test index and pass phase to EEPROM address and expected data byte
// Ports: i_idx byte index in the pass, i_phase inverts data on odd passes,
//        o_addr wrapped word address, o_data pattern byte.
module eeprom_pat_gen #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int SEED      = 'h12
) (
  input  logic [ADDR_W-1:0] i_idx,
  input  logic              i_phase,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);
  assign o_addr = ADDR_W'(BASE_ADDR) + i_idx;
  assign o_data = (DATA_W'(SEED) + DATA_W'(i_idx)) ^ {DATA_W{i_phase}};
endmodule

// File: rtl/eeprom_bist_seq.sv
// eeprom_bist_seq: EEPROM write/read-back self-test sequencer driving iic_com via Start_Sig/Done_Sig
// Ports: w_clk_out1 clock, w_RST_n async active-low reset; i_start/i_loop test control;
//        o_start_sig/o_addr/o_wrdata/i_rddata/i_done iic_com handshake;
//        o_busy/o_pass/o_fail/o_timeout/o_err_cnt/o_first_err_addr/o_pass_cnt/o_led status.
module eeprom_bist_seq
  import eeprom_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int NUM_BYTES      = 16,
  parameter int BASE_ADDR      = 0,
  parameter int SEED           = 'h12,
  parameter int WR_GAP_CYCLES  = 250000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ERR_W          = 8
) (
  input  logic              w_clk_out1,
  input  logic              w_RST_n,
  input  logic              i_start,
  input  logic              i_loop,
  output logic [1:0]        o_start_sig,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wrdata,
  input  logic [DATA_W-1:0] i_rddata,
  input  logic              i_done,
  output logic              o_busy,
  output logic              o_pass,
  output logic              o_fail,
  output logic              o_timeout,
  output logic [ERR_W-1:0]  o_err_cnt,
  output logic [ADDR_W-1:0] o_first_err_addr,
  output logic [15:0]       o_pass_cnt,
  output logic [3:0]        o_led
);
  localparam int GAP_W = $clog2(WR_GAP_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BYTES - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, addr_q, addr_d, first_q, first_d, pat_addr;
  logic [DATA_W-1:0] wrdata_q, wrdata_d, rd_q, rd_d, pat_data;
  logic [1:0] ss_q, ss_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic phase_q, phase_d, busy_q, busy_d, pass_q, pass_d, fail_q, fail_d, to_q, to_d;
  logic last, miss, expired;
  // Driven from next-state index/phase so o_addr/o_wrdata are registered and,
  // during CMP, still hold the address and expected byte of the read just done.
  eeprom_pat_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR), .SEED(SEED)
  ) u_pat (
    .i_idx(idx_d), .i_phase(phase_d), .o_addr(pat_addr), .o_data(pat_data)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    first_d = first_q;
    rd_d    = rd_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    pcnt_d  = pcnt_q;
    phase_d = phase_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    to_d    = to_q;
    last    = idx_q == LAST;
    miss    = rd_q != wrdata_q;
    expired = tmo_q == TMO_W'(TIMEOUT_CYCLES - 1);
    case (state_q)
      IDLE: if (i_start) begin
        state_d = WR_REQ;
        idx_d   = '0;
        err_d   = '0;
        first_d = '0;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        to_d    = 1'b0;
      end
      WR_REQ, RD_REQ: if (i_done) begin
        state_d = state_q == WR_REQ ? WR_GAP : CMP;
        gap_d   = GAP_W'(WR_GAP_CYCLES - 1);
        rd_d    = i_rddata;
      end else if (expired) begin
        state_d = DONE;
        to_d    = 1'b1;
      end else tmo_d = tmo_q + TMO_W'(1);
      WR_GAP: if (gap_q == '0) begin
        state_d = last ? RD_REQ : WR_REQ;
        idx_d   = last ? '0 : idx_q + ADDR_W'(1);
      end else gap_d = gap_q - GAP_W'(1);
      CMP: begin
        if (miss) begin
          first_d = err_q == '0 ? addr_q : first_q;
          err_d   = &err_q ? err_q : err_q + ERR_W'(1);
        end
        state_d = last ? DONE : RD_REQ;
        idx_d   = last ? idx_q : idx_q + ADDR_W'(1);
      end
      DONE: begin
        pass_d  = err_q == '0 && !to_q;
        fail_d  = !pass_d;
        pcnt_d  = pcnt_q + 16'd1;
        phase_d = !phase_q;
        state_d = i_loop ? WR_REQ : IDLE;
        if (i_loop) begin
          idx_d   = '0;
          err_d   = '0;
          first_d = '0;
          to_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Every state change restarts the per-request watchdog.
    tmo_d    = state_d == state_q ? tmo_d : '0;
    // Start is derived from the next state, so any exit from a request state
    // deasserts it for at least one cycle before the following request.
    ss_d     = state_d == WR_REQ ? IIC_WR : state_d == RD_REQ ? IIC_RD : IIC_IDLE;
    busy_d   = state_d != IDLE;
    addr_d   = pat_addr;
    wrdata_d = pat_data;
  end
  always_ff @(posedge w_clk_out1 or negedge w_RST_n)
    if (!w_RST_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      first_q  <= '0;
      rd_q     <= '0;
      ss_q     <= IIC_IDLE;
      gap_q    <= '0;
      tmo_q    <= '0;
      err_q    <= '0;
      pcnt_q   <= '0;
      phase_q  <= 1'b0;
      busy_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      first_q  <= first_d;
      rd_q     <= rd_d;
      ss_q     <= ss_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      pcnt_q   <= pcnt_d;
      phase_q  <= phase_d;
      busy_q   <= busy_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      to_q     <= to_d;
    end
  assign o_start_sig      = ss_q;
  assign o_addr           = addr_q;
  assign o_wrdata         = wrdata_q;
  assign o_busy           = busy_q;
  assign o_pass           = pass_q;
  assign o_fail           = fail_q;
  assign o_timeout        = to_q;
  assign o_err_cnt        = err_q;
  assign o_first_err_addr = first_q;
  assign o_pass_cnt       = pcnt_q;
  assign o_led            = {busy_q, pass_q, fail_q, to_q};
endmodule

// File: tb/tb_eeprom_bist_seq.sv
// tb_eeprom_bist_seq: directed self-checking bench with a behavioural iic_com/EEPROM model
module tb_eeprom_bist_seq;
  logic clk = 1'b0, rst_n = 1'b1, i_start = 1'b0, i_loop = 1'b0, i_done;
  logic [7:0] i_rddata, addr, wd, first;
  logic [1:0] ss, errc;
  logic busy, pass, fail, tmo;
  logic [15:0] pcnt;
  logic [3:0] led;
  int vec = 0, bad = 0;
  logic [7:0] mem [256];
  logic stuck = 1'b0, corrupt00 = 1'b0, all_wrong = 1'b0;
  logic [1:0] prev, last_cmd;
  int cnt, zero_run, min_gap, nreads;
  logic [15:0] wlog [$];
  logic [15:0] wexp [8] = '{16'hFE12, 16'hFF13, 16'h0014, 16'h0115,
                            16'hFEED, 16'hFFEC, 16'h00EB, 16'h01EA};
  always #5 clk = ~clk;
  eeprom_bist_seq #(
    .ADDR_W(8), .DATA_W(8), .NUM_BYTES(4), .BASE_ADDR('hFE), .SEED('h12),
    .WR_GAP_CYCLES(8), .TIMEOUT_CYCLES(50), .ERR_W(2)
  ) dut (
    .w_clk_out1(clk), .w_RST_n(rst_n), .i_start(i_start), .i_loop(i_loop),
    .o_start_sig(ss), .o_addr(addr), .o_wrdata(wd), .i_rddata(i_rddata), .i_done(i_done),
    .o_busy(busy), .o_pass(pass), .o_fail(fail), .o_timeout(tmo), .o_err_cnt(errc),
    .o_first_err_addr(first), .o_pass_cnt(pcnt), .o_led(led)
  );
  // iic_com + EEPROM model: Done three cycles after a fresh start, logs writes and write gaps
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      i_done <= 1'b0; i_rddata <= '0; cnt <= 0; prev <= '0; last_cmd <= '0;
      zero_run <= 0; min_gap <= 1000; nreads <= 0; wlog.delete();
    end else begin
      i_done <= 1'b0;
      prev <= ss;
      if (ss == 2'b00) zero_run <= zero_run + 1;
      else if (prev == 2'b00) begin
        if (last_cmd == 2'b01 && zero_run < min_gap) min_gap <= zero_run;
        last_cmd <= ss; zero_run <= 0; cnt <= 3;
      end else if (cnt > 0 && !stuck) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          i_done <= 1'b1;
          if (ss == 2'b01) begin
            mem[addr] <= wd;
            wlog.push_back({addr, wd});
          end else begin
            nreads <= nreads + 1;
            i_rddata <= all_wrong ? ~mem[addr] : (corrupt00 && addr == 8'h00) ? 8'h00 : mem[addr];
          end
        end
      end
    end
  task automatic do_reset();
    rst_n = 1'b0; i_start = 1'b0; i_loop = 1'b0; stuck = 1'b0; corrupt00 = 1'b0; all_wrong = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    vec++;
    if (busy) begin bad++; $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n); end
  endtask
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1 vec++;
    if ({ss, addr, wd, busy, pass, fail, tmo, errc, first, pcnt, led} !== 52'd0) begin
      bad++; $display("FAIL reset_outputs: got %h, required 0", {ss, addr, wd, busy, pass, fail, tmo, errc, first, pcnt, led});
    end
    do_reset();
  endtask
  task automatic test_good_pass();
    do_reset();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    vec++;
    if ({ss, addr, wd, busy} !== {2'b01, 8'hFE, 8'h12, 1'b1}) begin
      bad++; $display("FAIL first_req: ss=%b addr=%h wd=%h busy=%b, required 01 fe 12 1", ss, addr, wd, busy);
    end
    wait_idle("good");
    vec++;
    if (wlog.size() != 4) begin bad++; $display("FAIL good_wr_count: got %0d, required 4", wlog.size()); end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      vec++;
      if (wlog[i] !== wexp[i]) begin bad++; $display("FAIL good_wr%0d: got %h, required %h", i, wlog[i], wexp[i]); end
    end
    vec++;
    if (min_gap < 8) begin bad++; $display("FAIL good_wr_gap: got %0d idle cycles, required >=8", min_gap); end
    vec++;
    if (nreads != 4) begin bad++; $display("FAIL good_rd_count: got %0d, required 4", nreads); end
    vec++;
    if ({led, errc, pcnt} !== {4'b0100, 2'd0, 16'd1}) begin
      bad++; $display("FAIL good_status: led=%b err=%0d pcnt=%0d, required 0100 0 1", led, errc, pcnt);
    end
  endtask
  task automatic test_corrupt();
    do_reset();
    corrupt00 = 1'b1;
    pulse_start();
    wait_idle("corrupt");
    vec++;
    if ({led, errc, first} !== {4'b0010, 2'd1, 8'h00}) begin
      bad++; $display("FAIL corrupt_status: led=%b err=%0d first=%h, required 0010 1 00", led, errc, first);
    end
  endtask
  task automatic test_timeout();
    int n = 0;
    do_reset();
    stuck = 1'b1;
    pulse_start();
    while (ss != 2'b00 && n < 200) begin @(negedge clk); n++; end
    vec++;
    if (n != 50) begin bad++; $display("FAIL timeout_cycles: start dropped after %0d cycles, required 50", n); end
    wait_idle("timeout");
    vec++;
    if ({led, pcnt} !== {4'b0011, 16'd1}) begin
      bad++; $display("FAIL timeout_status: led=%b pcnt=%0d, required 0011 1", led, pcnt);
    end
    vec++;
    if (wlog.size() != 0) begin bad++; $display("FAIL timeout_writes: got %0d, required 0", wlog.size()); end
  endtask
  task automatic test_loop();
    int n = 0;
    do_reset();
    corrupt00 = 1'b1;
    i_loop = 1'b1;
    pulse_start();
    while (pcnt != 16'd1 && n < 2000) begin @(negedge clk); n++; end
    corrupt00 = 1'b0;
    vec++;
    if ({pcnt, fail, errc, busy} !== {16'd1, 1'b1, 2'd0, 1'b1}) begin
      bad++; $display("FAIL loop_restart: pcnt=%0d fail=%b err=%0d busy=%b, required 1 1 0 1", pcnt, fail, errc, busy);
    end
    i_loop = 1'b0;
    wait_idle("loop");
    vec++;
    if ({pcnt, led, errc} !== {16'd2, 4'b0100, 2'd0}) begin
      bad++; $display("FAIL loop_status: pcnt=%0d led=%b err=%0d, required 2 0100 0", pcnt, led, errc);
    end
    vec++;
    if (wlog.size() != 8) begin bad++; $display("FAIL loop_wr_count: got %0d, required 8", wlog.size()); end
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      vec++;
      if (wlog[i] !== wexp[i]) begin bad++; $display("FAIL loop_wr%0d: got %h, required %h", i, wlog[i], wexp[i]); end
    end
  endtask
  task automatic test_saturate();
    do_reset();
    all_wrong = 1'b1;
    pulse_start();
    wait_idle("saturate");
    vec++;
    if ({errc, first, fail} !== {2'd3, 8'hFE, 1'b1}) begin
      bad++; $display("FAIL saturate: err=%0d first=%h fail=%b, required 3 fe 1", errc, first, fail);
    end
  endtask
  task automatic test_busy_start();
    int n = 0;
    do_reset();
    pulse_start();
    while (ss != 2'b00 && n < 200) begin @(negedge clk); n++; end
    pulse_start();
    vec++;
    if ({ss, busy} !== {2'b00, 1'b1}) begin
      bad++; $display("FAIL busy_start_gap: ss=%b busy=%b, required 00 1", ss, busy);
    end
    wait_idle("busy_start");
    vec++;
    if ({wlog.size() == 4, pcnt, led} !== {1'b1, 16'd1, 4'b0100}) begin
      bad++; $display("FAIL busy_start_result: writes=%0d pcnt=%0d led=%b, required 4 1 0100", wlog.size(), pcnt, led);
    end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    pulse_start();
    while (ss != 2'b10 && n < 500) begin @(negedge clk); n++; end
    vec++;
    if (ss !== 2'b10) begin bad++; $display("FAIL mid_reach_read: ss=%b, required 10", ss); end
    #1 rst_n = 1'b0;
    #1 vec++;
    if ({ss, addr, wd, busy, pass, fail, tmo, errc, first, pcnt, led} !== 52'd0) begin
      bad++; $display("FAIL mid_reset_outputs: got %h, required 0", {ss, addr, wd, busy, pass, fail, tmo, errc, first, pcnt, led});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_good_pass();
    test_corrupt();
    test_timeout();
    test_loop();
    test_saturate();
    test_busy_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
